// File: rtl/booth_mult_sched.sv
// Round-robin scheduler that time-shares one combinational multicycle multiplier among NUM_REQ requesters.
// Optional per-requester product accumulation is enabled by defining BMS_ACC_EN.
module booth_mult_sched #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int BIT_CNT       = 16,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BIT_CNT-1:0] req_x,
    input  logic [NUM_REQ*BIT_CNT-1:0] req_y,
    input  logic [NUM_REQ-1:0]         req_acc,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [BIT_CNT-1:0]         mult_x,
    output logic [BIT_CNT-1:0]         mult_y,
    input  logic [2*BIT_CNT-1:0]       mult_p,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [2*BIT_CNT-1:0]       rsp_product,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      id_q;
    logic [CNT_W-1:0]     cnt;
    logic                 found;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      cand;
    logic                 accept;
    logic                 capture;
    logic [2*BIT_CNT-1:0] cap_value;

    // Scan from rr_ptr upwards, wrapping, and stop at the first valid requester.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
    end

    assign accept  = (state == IDLE) && found;
    assign capture = (state == SETTLE) && (cnt == '0);
    assign busy    = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

`ifdef BMS_ACC_EN
    logic [2*BIT_CNT-1:0] acc [NUM_REQ];
    logic                 acc_q;

    // A cleared acc flag restarts the chain from the bare product; the sum wraps at 2*BIT_CNT bits.
    assign cap_value = acc_q ? (acc[id_q] + mult_p) : mult_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (accept) begin
                acc_q <= req_acc[grant_id];
            end
            if (capture) begin
                acc[id_q] <= cap_value;
            end
        end
    end
`else
    logic unused_req_acc;

    assign unused_req_acc = ^req_acc;
    assign cap_value      = mult_p;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            id_q        <= '0;
            cnt         <= '0;
            mult_x      <= '0;
            mult_y      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mult_x <= req_x[int'(grant_id)*BIT_CNT +: BIT_CNT];
                        mult_y <= req_y[int'(grant_id)*BIT_CNT +: BIT_CNT];
                        id_q   <= grant_id;
                        rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
                        cnt    <= CNT_W'(SETTLE_CYCLES - 1);
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        rsp_product <= cap_value;
                        rsp_id      <= id_q;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_sched.sv
// Self-checking bench for booth_mult_sched: a cycle-level reference model checked every cycle plus directed scenarios.
// A behavioural product stands in for the multiplier; build with BMS_ACC_EN to exercise accumulation.
module tb_booth_mult_sched;

    localparam int NR = 4;
    localparam int BW = 16;
    localparam int SC = 3;

`ifdef BMS_ACC_EN
    localparam logic [31:0] EXP_T6B = 32'd26;
    localparam logic [31:0] EXP_T6C = 32'hFFFE001B;
`else
    localparam logic [31:0] EXP_T6B = 32'd20;
    localparam logic [31:0] EXP_T6C = 32'hFFFE0001;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*BW-1:0]  req_x;
    logic [NR*BW-1:0]  req_y;
    logic [NR-1:0]     req_acc;
    logic [NR-1:0]     req_ready;
    logic [BW-1:0]     mult_x;
    logic [BW-1:0]     mult_y;
    logic [2*BW-1:0]   mult_p;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [2*BW-1:0]   rsp_product;
    logic              rsp_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    // Reference model state: a transaction is either settling until cycle m_due, or waiting in the response slot.
    bit          m_busy;
    bit          m_resp;
    int          m_rr;
    logic [1:0]  m_id;
    logic [15:0] m_x;
    logic [15:0] m_y;
    logic [31:0] m_prod;
    logic [1:0]  m_rsp_id;
    int          cyc;
    int          m_due;
    logic [63:0] m_full;
`ifdef BMS_ACC_EN
    logic        m_flag;
    logic [31:0] m_acc [NR];
`endif

    booth_mult_sched #(
        .NUM_REQ(NR),
        .ID_W(2),
        .BIT_CNT(BW),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_x(req_x),
        .req_y(req_y),
        .req_acc(req_acc),
        .req_ready(req_ready),
        .mult_x(mult_x),
        .mult_y(mult_y),
        .mult_p(mult_p),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_product(rsp_product),
        .rsp_ready(rsp_ready),
        .busy(busy)
    );

    assign mult_p = 32'(mult_x) * 32'(mult_y);

    initial forever #5 clk = ~clk;

    function automatic int firstValid(input logic [3:0] v, input int rr);
        logic [1:0] idx;
        for (int k = 0; k < NR; k++) begin
            idx = 2'((rr + k) % NR);
            if (v[idx]) return int'(idx);
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input int idx, input logic [15:0] x,
                                 input logic [15:0] y, input logic acc);
        req_valid           = valid;
        req_x[idx*BW +: BW] = x;
        req_y[idx*BW +: BW] = y;
        req_acc[idx]        = acc;
    endtask

    task automatic waitResponse(output int lat);
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) break;
        end
        if (rsp_valid !== 1'b1) checkOutput("rsp_timeout", 64'(rsp_valid), 64'(1));
    endtask

    task automatic serve(input string name, input int idx, input logic [15:0] x, input logic [15:0] y,
                         input logic acc, input logic [1:0] exp_id, input logic [31:0] exp_prod);
        int lat;
        tick();
        applyStimulus(4'(1 << idx), idx, x, y, acc);
        tick();
        req_valid = 4'b0000;
        waitResponse(lat);
        checkOutput({name, "_id"}, 64'(rsp_id), 64'(exp_id));
        checkOutput({name, "_product"}, 64'(rsp_product), 64'(exp_prod));
        tick();
    endtask

    // Model update on every rising edge, using the same input values the DUT samples.
    initial forever begin
        int g;
        @(posedge clk);
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_resp   = 1'b0;
            m_rr     = 0;
            m_id     = 2'd0;
            m_x      = '0;
            m_y      = '0;
            m_prod   = '0;
            m_rsp_id = 2'd0;
`ifdef BMS_ACC_EN
            m_flag   = 1'b0;
            for (int i = 0; i < NR; i++) m_acc[i] = '0;
`endif
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_resp = 1'b0;
                m_busy = 1'b0;
            end
        end else if (m_busy) begin
            if (cyc == m_due) begin
                m_full = 64'(m_x) * 64'(m_y);
`ifdef BMS_ACC_EN
                if (m_flag) m_full = (m_full + 64'(m_acc[m_id])) & 64'hFFFF_FFFF;
                m_acc[m_id] = m_full[31:0];
`endif
                m_prod   = m_full[31:0];
                m_rsp_id = m_id;
                m_resp   = 1'b1;
            end
        end else begin
            g = firstValid(req_valid, m_rr);
            if (g >= 0) begin
                m_x    = req_x[g*BW +: BW];
                m_y    = req_y[g*BW +: BW];
                m_id   = 2'(g);
`ifdef BMS_ACC_EN
                m_flag = req_acc[g];
`endif
                m_rr   = (g + 1) % NR;
                m_busy = 1'b1;
                m_due  = cyc + SC;
            end
        end
        cyc++;
    end

    // Compare every visible output against the model on each falling edge.
    initial forever begin
        int g;
        logic [3:0] exp_ready;
        @(negedge clk);
        if (model_on) begin
            exp_ready = 4'b0000;
            g = firstValid(req_valid, m_rr);
            if (rst_n && !m_busy && g >= 0) exp_ready[g] = 1'b1;
            checkOutput("model_req_ready", 64'(req_ready), 64'(exp_ready));
            checkOutput("model_busy", 64'(busy), 64'(m_busy));
            checkOutput("model_rsp_valid", 64'(rsp_valid), 64'(m_resp));
            checkOutput("model_rsp_id", 64'(rsp_id), 64'(m_rsp_id));
            checkOutput("model_rsp_product", 64'(rsp_product), 64'(m_prod));
            checkOutput("model_mult_x", 64'(mult_x), 64'(m_x));
            checkOutput("model_mult_y", 64'(mult_y), 64'(m_y));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic [1:0]  ord [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [31:0] prd [5] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd10};

        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_acc   = '0;
        rsp_ready = 1'b1;
        m_busy    = 1'b0;
        m_resp    = 1'b0;
        cyc       = 0;
        m_due     = 0;
        tick();
        tick();
        model_on = 1'b1;

        @(negedge clk);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_mult_x", 64'(mult_x), 64'(0));
        checkOutput("reset_rsp_product", 64'(rsp_product), 64'(0));
        tick();
        rst_n = 1'b1;

        $display("[TB] single request latency");
        applyStimulus(4'b0001, 0, 16'd3, 16'd5, 1'b0);
        @(negedge clk);
        checkOutput("t1_req_ready", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = 4'b0000;
        waitResponse(lat);
        checkOutput("t1_latency", 64'(lat), 64'(4));
        checkOutput("t1_id", 64'(rsp_id), 64'(0));
        checkOutput("t1_product", 64'(rsp_product), 64'(15));
        tick();
        @(negedge clk);
        checkOutput("t1_busy_after", 64'(busy), 64'(0));

        $display("[TB] operand extremes");
        serve("t2_max", 1, 16'hFFFF, 16'hFFFF, 1'b0, 2'd1, 32'hFFFE0001);
        serve("t2_zero", 1, 16'h0000, 16'h1234, 1'b0, 2'd1, 32'd0);

        $display("[TB] round-robin order");
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) applyStimulus(4'b1111, i, 16'(i + 1), 16'd10, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            waitResponse(lat);
            checkOutput("t3_order", 64'(rsp_id), 64'(ord[n]));
            checkOutput("t3_product", 64'(rsp_product), 64'(prd[n]));
            tick();
            if (n == 4) req_valid = 4'b0100;
        end
        waitResponse(lat);
        checkOutput("t3_only2_id", 64'(rsp_id), 64'(2));
        checkOutput("t3_only2_product", 64'(rsp_product), 64'(30));
        tick();
        req_valid = 4'b0000;

        $display("[TB] response backpressure");
        tick();
        rsp_ready = 1'b0;
        applyStimulus(4'b0010, 1, 16'd7, 16'd9, 1'b0);
        tick();
        applyStimulus(4'b1000, 3, 16'd2, 16'd2, 1'b0);
        waitResponse(lat);
        for (int n = 0; n < 10; n++) begin
            checkOutput("t4_hold_valid", 64'(rsp_valid), 64'(1));
            checkOutput("t4_hold_id", 64'(rsp_id), 64'(1));
            checkOutput("t4_hold_product", 64'(rsp_product), 64'(63));
            checkOutput("t4_no_grant", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        tick();
        tick();
        req_valid = 4'b0000;
        waitResponse(lat);
        checkOutput("t4_next_id", 64'(rsp_id), 64'(3));
        checkOutput("t4_next_product", 64'(rsp_product), 64'(4));
        tick();

        $display("[TB] reset during settle");
        tick();
        applyStimulus(4'b0001, 0, 16'd5, 16'd6, 1'b0);
        tick();
        req_valid = 4'b0000;
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("t5_mult_x", 64'(mult_x), 64'(0));
        checkOutput("t5_mult_y", 64'(mult_y), 64'(0));
        checkOutput("t5_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("t5_rsp_id", 64'(rsp_id), 64'(0));
        checkOutput("t5_rsp_product", 64'(rsp_product), 64'(0));
        checkOutput("t5_busy", 64'(busy), 64'(0));
        checkOutput("t5_req_ready", 64'(req_ready), 64'(0));
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            checkOutput("t5_no_response", 64'(rsp_valid), 64'(0));
        end
        serve("t5_after", 2, 16'd11, 16'd13, 1'b0, 2'd2, 32'd143);

        $display("[TB] accumulate chain");
        serve("t6_a", 3, 16'd2, 16'd3, 1'b0, 2'd3, 32'd6);
        serve("t6_b", 3, 16'd4, 16'd5, 1'b1, 2'd3, EXP_T6B);
        serve("t6_c", 3, 16'hFFFF, 16'hFFFF, 1'b1, 2'd3, EXP_T6C);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
